// File: rtl/hub75_pkg.sv
// Shared HUB75 panel geometry and pixel word layout (0x00RRGGBB),
// common to the SPI receiver and the scan-out controller.
package hub75_pkg;

   localparam int PANEL_WIDTH     = 64;
   localparam int PANEL_HEIGHT    = 32;
   localparam int PIX_BITS        = $clog2(PANEL_WIDTH * PANEL_HEIGHT);
   localparam int PIXEL_WORD_BITS = 32;

   localparam int COLOR_BITS = 8;
   localparam int BLUE_LSB   = 0;
   localparam int GREEN_LSB  = 8;
   localparam int RED_LSB    = 16;

   typedef struct packed {
      logic [COLOR_BITS-1:0] pad;
      logic [COLOR_BITS-1:0] red;
      logic [COLOR_BITS-1:0] green;
      logic [COLOR_BITS-1:0] blue;
   } pixel_word_t;

   function automatic logic [COLOR_BITS-1:0] pixel_red(input logic [PIXEL_WORD_BITS-1:0] w);
      return w[RED_LSB +: COLOR_BITS];
   endfunction

   function automatic logic [COLOR_BITS-1:0] pixel_green(input logic [PIXEL_WORD_BITS-1:0] w);
      return w[GREEN_LSB +: COLOR_BITS];
   endfunction

   function automatic logic [COLOR_BITS-1:0] pixel_blue(input logic [PIXEL_WORD_BITS-1:0] w);
      return w[BLUE_LSB +: COLOR_BITS];
   endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchroniser for an edge source plus companion data bits,
// all through one chain so they stay aligned; rising-edge pulse on the source.
module sync_edge_detect #(
   parameter int SYNC_STAGES = 2,
   parameter int W           = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         edge_in,
   input  logic [W-1:0] data_in,
   output logic [W-1:0] data_q,
   output logic         rise
);

   logic [SYNC_STAGES-1:0][W:0] sync_q, sync_d;
   logic                        prev_q, prev_d;
   logic [W:0]                  synced;

   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], {data_in, edge_in}};
      synced = sync_q[SYNC_STAGES-1];
      prev_d = synced[0];
      rise   = synced[0] & ~prev_q;
      data_q = synced[W:1];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= sync_d;
         prev_q <= prev_d;
      end
   end

endmodule

// File: rtl/spi_pixel_receiver.sv
// Deserialises the host SPI pixel stream into framebuffer writes and
// manages the double-buffer toggle; everything runs on pixel_clk.
module spi_pixel_receiver
   import hub75_pkg::*;
#(
   parameter  int WIDTH        = PANEL_WIDTH,
   parameter  int HEIGHT       = PANEL_HEIGHT,
   parameter  int WORD_BITS    = PIXEL_WORD_BITS,
   parameter  int SYNC_STAGES  = 2,
   parameter  int IDLE_TIMEOUT = 1024,
   localparam int IDX_BITS     = $clog2(WIDTH * HEIGHT)
) (
   input  logic                 pixel_clk,
   input  logic                 reset,
   input  logic                 spi_clk,
   input  logic                 spi_mosi,
   output logic                 wr_en,
   output logic [IDX_BITS:0]    wr_addr,
   output logic [WORD_BITS-1:0] wr_data,
   output logic                 write_buffer,
   output logic                 frame_done,
   output logic                 sync_error
);

   localparam int BC_BITS   = $clog2(WORD_BITS);
   localparam int IDLE_BITS = $clog2(IDLE_TIMEOUT + 1);

   localparam logic [BC_BITS-1:0]   LAST_BIT = BC_BITS'(WORD_BITS - 1);
   localparam logic [IDX_BITS-1:0]  LAST_PIX = IDX_BITS'(WIDTH * HEIGHT - 1);
   localparam logic [IDLE_BITS-1:0] IDLE_MAX = IDLE_BITS'(IDLE_TIMEOUT);

   logic spi_edge;
   logic mosi_s;

   logic [WORD_BITS-1:0] shift_q, shift_d;
   logic [BC_BITS-1:0]   bit_count_q, bit_count_d;
   logic [IDX_BITS-1:0]  pixel_index_q, pixel_index_d;
   logic                 write_buffer_q, write_buffer_d;
   logic [IDLE_BITS-1:0] idle_q, idle_d;
   logic                 wr_en_q, wr_en_d;
   logic [IDX_BITS:0]    wr_addr_q, wr_addr_d;
   logic [WORD_BITS-1:0] wr_data_q, wr_data_d;
   logic                 frame_done_q, frame_done_d;
   logic                 sync_error_q, sync_error_d;
   logic [WORD_BITS-1:0] word_next;

   sync_edge_detect #(
      .SYNC_STAGES(SYNC_STAGES),
      .W          (1)
   ) u_sync (
      .clk    (pixel_clk),
      .rst_n  (reset),
      .edge_in(spi_clk),
      .data_in(spi_mosi),
      .data_q (mosi_s),
      .rise   (spi_edge)
   );

   always_comb begin
      shift_d        = shift_q;
      bit_count_d    = bit_count_q;
      pixel_index_d  = pixel_index_q;
      write_buffer_d = write_buffer_q;
      idle_d         = idle_q;
      wr_en_d        = 1'b0;
      wr_addr_d      = wr_addr_q;
      wr_data_d      = wr_data_q;
      frame_done_d   = 1'b0;
      sync_error_d   = 1'b0;
      word_next      = {shift_q[WORD_BITS-2:0], mosi_s};

      // Index advance follows the strobe by a cycle; the 2-cycle minimum
      // SPI phase guarantees no edge can land in this cycle.
      if (wr_en_q) begin
         pixel_index_d = pixel_index_q + 1'b1;
         if (frame_done_q) begin
            write_buffer_d = ~write_buffer_q;
         end
      end

      if (spi_edge) begin
         idle_d  = '0;
         shift_d = word_next;
         if (bit_count_q == LAST_BIT) begin
            bit_count_d  = '0;
            wr_en_d      = 1'b1;
            wr_data_d    = word_next;
            wr_addr_d    = {write_buffer_q, pixel_index_q};
            frame_done_d = (pixel_index_q == LAST_PIX);
         end else begin
            bit_count_d = bit_count_q + 1'b1;
         end
      end else if (idle_q != IDLE_MAX) begin
         idle_d = idle_q + 1'b1;
      end else if ((bit_count_q != '0) || (pixel_index_q != '0)) begin
         bit_count_d   = '0;
         pixel_index_d = '0;
         sync_error_d  = 1'b1;
      end
   end

   always_ff @(posedge pixel_clk or negedge reset) begin
      if (!reset) begin
         shift_q        <= '0;
         bit_count_q    <= '0;
         pixel_index_q  <= '0;
         write_buffer_q <= 1'b0;
         idle_q         <= '0;
         wr_en_q        <= 1'b0;
         wr_addr_q      <= '0;
         wr_data_q      <= '0;
         frame_done_q   <= 1'b0;
         sync_error_q   <= 1'b0;
      end else begin
         shift_q        <= shift_d;
         bit_count_q    <= bit_count_d;
         pixel_index_q  <= pixel_index_d;
         write_buffer_q <= write_buffer_d;
         idle_q         <= idle_d;
         wr_en_q        <= wr_en_d;
         wr_addr_q      <= wr_addr_d;
         wr_data_q      <= wr_data_d;
         frame_done_q   <= frame_done_d;
         sync_error_q   <= sync_error_d;
      end
   end

   always_comb begin
      wr_en        = wr_en_q;
      wr_addr      = wr_addr_q;
      wr_data      = wr_data_q;
      write_buffer = write_buffer_q;
      frame_done   = frame_done_q;
      sync_error   = sync_error_q;
   end

endmodule

// File: doc/spi_pixel_receiver.md
Name: spi_pixel_receiver

Overview:
- Upstream stage of the HUB75 controller. Deserialises the host SPI pixel stream into 32-bit words (0x00RRGGBB) and issues framebuffer write strobes.
- Manages double buffering. It fills one 64x32 buffer and toggles to the other on each complete frame; the scan-out side always reads the buffer not being written.
- SPI is sampled and oversampled in the pixel_clk domain. There is no second clock.

Parameters:
- WIDTH, 64, panel columns.
- HEIGHT, 32, panel rows. WIDTH*HEIGHT must be a power of two; PIX_BITS = log2(WIDTH*HEIGHT) = 11.
- WORD_BITS, 32, bits per pixel word on the wire.
- SYNC_STAGES, 2, synchroniser flops on spi_clk and spi_mosi (minimum 2).
- IDLE_TIMEOUT, 1024, pixel_clk cycles without an spi_clk rising edge before resync.

Ports:
- pixel_clk  in  1  sole clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-low reset; 0 = in reset.
- spi_clk  in  1  host SPI clock, asynchronous to pixel_clk. Idles low; data sampled on its rising edge.
- spi_mosi  in  1  host SPI data, MSB of each word first.
- wr_en  out  1  one-cycle framebuffer write strobe.
- wr_addr  out  PIX_BITS+1  {write_buffer, pixel_index}; pixel_index = row*WIDTH + col.
- wr_data  out  WORD_BITS  completed pixel word.
- write_buffer  out  1  buffer currently being filled; the display reads ~write_buffer.
- frame_done  out  1  one-cycle pulse on the final pixel write of a frame.
- sync_error  out  1  one-cycle pulse when the idle timeout discards a partial word or frame.

Behaviour:
- Reset values (asserted asynchronously): wr_en=0, wr_addr=0, wr_data=0, write_buffer=0, frame_done=0, sync_error=0. Internal bit_count=0, pixel_index=0, idle counter=0, synchronisers=0.
- Synchronisers: spi_clk and spi_mosi each pass SYNC_STAGES flops, with equal depth so they stay aligned.
  - Edge = synced spi_clk is 1 and was 0 in the previous cycle.
  - Requirement: spi_clk high and low phases are each >= 2 pixel_clk periods. Faster input is out of spec.
- Shift: on each edge cycle, shift_reg <= {shift_reg[WORD_BITS-2:0], synced_mosi} and bit_count increments.
- Word complete: if the edge cycle brings bit_count to WORD_BITS, then on the next cycle:
  - wr_en=1 for exactly one cycle.
  - wr_data = the assembled word.
  - wr_addr = {write_buffer, pixel_index}.
  - bit_count returns to 0.
  - Latency: 1 cycle from the synchronised 32nd edge to wr_en.
- wr_data and wr_addr hold their values while wr_en=0.
- After each write, pixel_index increments. On the write where pixel_index = WIDTH*HEIGHT-1:
  - frame_done=1 in the same cycle as wr_en.
  - The next cycle: pixel_index wraps to 0 and write_buffer toggles.
  - The first write of the next frame therefore targets the other buffer.
- Idle timeout: the idle counter clears on every edge and otherwise increments, saturating at IDLE_TIMEOUT.
  - When it reaches IDLE_TIMEOUT and bit_count != 0 or pixel_index != 0: for one cycle, clear bit_count and pixel_index and pulse sync_error=1.
  - write_buffer is unchanged, so the next word restarts the current buffer at pixel 0.
  - When bit_count=0 and pixel_index=0, the timeout is silent.
- Simultaneous events: an edge in the timeout cycle takes priority. The timeout is suppressed, the counter clears and the shift proceeds.
- Reset mid-word or mid-frame discards everything, including the write_buffer state. The host must restart the frame.
- No backpressure: the framebuffer must accept a write in any cycle.

Decomposition:
- Shared package (hub75_pkg): PANEL_WIDTH, PANEL_HEIGHT, PIX_BITS, PIXEL_WORD_BITS and the 0x00RRGGBB field offsets. The scan-out controller uses the same package.
- One natural sub-module: sync_edge_detect. It contains the SYNC_STAGES synchroniser plus the rising-edge pulse, and is instantiated for spi_clk; the same synchroniser chain is used for mosi.

Test Plan:
- Reset: hold reset=0 with spi toggling -> all outputs 0 and no wr_en. Release reset and send 0x00FF0000 -> wr_en once, wr_addr=0x000, wr_data=0x00FF0000.
- Single word: send 0x12345678 MSB-first with spi_clk period 8 pixel_clk -> wr_en exactly 1 cycle after the 32nd synchronised edge, wr_data=0x12345678, no other strobes.
- Full frame: stream 2048 words where word i = i -> 2048 strobes with wr_addr = i and wr_data = i. frame_done coincides with wr_addr=0x7FF, and write_buffer=1 afterwards.
- Second frame: continue with 2048 more words -> first write has wr_addr=0x800, last has wr_addr=0xFFF. frame_done pulses again and write_buffer returns to 0.
- Partial-word timeout: send 13 bits, idle 1024 cycles -> sync_error pulses once. Then send 0x00ABCDEF -> wr_addr=0x000, wr_data=0x00ABCDEF.
- Mid-frame timeout and edge collision: after 100 words, idle -> sync_error pulses and the next word goes to pixel 0 with write_buffer unchanged. Then, with an edge landing on the timeout cycle -> no sync_error and the bit is shifted in.
